serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) with a recirculating
// carry, LSB-first. Optional signed-overflow flag built when SERIAL_ADDER_OVF_EN is defined.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_rs;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic w_s1, w_c1, w_s, w_c2, w_co;
  logic w_last;
  logic w_accept;

  half_adder u_ha0 (.a(r_ra[0]), .b(r_rb[0]), .s(w_s1), .co(w_c1));
  half_adder u_ha1 (.a(w_s1),    .b(r_c),     .s(w_s),  .co(w_c2));
  assign w_co = w_c1 | w_c2;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && start;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rs    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_c     <= cin;
            r_rs    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_rs  <= {w_s, r_rs[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_rs;
  assign cout = r_c;

`ifdef SERIAL_ADDER_OVF_EN
  // Overflow = carry into the MSB xor carry out of it, captured as the MSB is processed.
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= r_c ^ w_co;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random additions, scoreboard
// checked by an independent monitor on every done pulse.

module tb_serial_adder;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    exp_t         e;
    logic [W:0]   full;
    full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
`ifdef SERIAL_ADDER_OVF_EN
    e.ovf  = (ma[W-1] == mb[W-1]) && (e.sum[W-1] != ma[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse is compared against the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_not_with_busy", busy, 1'b0);
        check("done_single_cycle", prev_done, 1'b0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
        end
      end
      prev_done = done;
    end
  end

  // Issues one addition and checks latency and busy duration. With in_done_cycle set,
  // start is raised immediately (caller is sitting in a done cycle).
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input bit in_done_cycle);
    int j;
    int busy_cnt;
    if (!in_done_cycle) @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    sb_q.push_back(model(ta, tb_v, tc));
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    j        = 0;
    busy_cnt = 0;
    while (!done && j < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      j++;
    end
    check("latency", j, W);
    check("busy_cycles", busy_cnt, W);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run_add(8'h05, 8'h03, 1'b0, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_add(8'h7F, 8'h01, 1'b0, 1'b0);
    run_add(8'h80, 8'h80, 1'b0, 1'b0);
    run_add(8'h10, 8'h20, 1'b0, 1'b0);

    // Start in the done cycle: accepted without an idle gap
    run_add(8'h01, 8'h01, 1'b0, 1'b1);

    // Start while busy must be ignored
    begin
      int j;
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      sb_q.push_back(model(8'h11, 8'h22, 1'b0));
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      j = 0;
      while (!done && j < 40) begin
        @(negedge clk);
        j++;
      end
      check("ignored_start_done_seen", done, 1'b1);
      repeat (W + 3) @(negedge clk);
      check("no_extra_done", sb_q.size(), 0);
    end

    // Asynchronous reset mid-run discards the partial result
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_sum", sum, '0);
    check("async_rst_cout", cout, 1'b0);
    check("async_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_add(8'h0A, 8'h05, 1'b0, 1'b0);

    // Randomised additions, some issued back-to-back in the done cycle
    for (int i = 0; i < 24; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
